// File: rtl/tinyrv1_mem_pkg.sv
// Shared types and helpers for the TinyRV1 memory responder.
// Request type encodings, response record and address legality check.
package tinyrv1_mem_pkg;

    localparam logic MEMREQ_READ  = 1'b0;
    localparam logic MEMREQ_WRITE = 1'b1;

    typedef struct packed {
        logic        val;
        logic [31:0] data;
    } mem_resp_t;

    // Legal means word aligned and inside the populated array.
    function automatic logic addr_legal(input logic [31:0] addr, input int unsigned num_words);
        return (addr[1:0] == 2'b00) && (addr < (num_words << 2));
    endfunction

endpackage

// File: rtl/proc_mem_resp_pipe.sv
// Fixed-latency response shift register; degenerates to a wire when LATENCY is 0.
module proc_mem_resp_pipe
    import tinyrv1_mem_pkg::*;
#(
    parameter int unsigned LATENCY = 0
) (
    input  logic      clk,
    input  logic      rst,
    input  mem_resp_t resp_i,
    output mem_resp_t resp_o
);

    if (LATENCY == 0) begin : g_wire
        logic unused_clk_rst;
        assign unused_clk_rst = clk ^ rst;
        assign resp_o = resp_i;
    end else begin : g_pipe
        mem_resp_t stage_q [LATENCY];
        mem_resp_t stage_d [LATENCY];

        always_comb begin
            stage_d[0] = resp_i;
            for (int i = 1; i < LATENCY; i++) begin
                stage_d[i] = stage_q[i-1];
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int i = 0; i < LATENCY; i++) begin
                    stage_q[i] <= '0;
                end
            end else begin
                stage_q <= stage_d;
            end
        end

        assign resp_o = stage_q[LATENCY-1];
    end

endmodule

// File: rtl/proc_mem.sv
// Dual-port word memory answering TinyRV1 fetch and load/store requests,
// with a bench preload port and a sticky illegal-access flag.
module proc_mem
    import tinyrv1_mem_pkg::*;
#(
    parameter int unsigned NUM_WORDS = 256,
    parameter int unsigned LATENCY   = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        imemreq_val,
    input  logic [31:0] imemreq_addr,
    output logic        imemresp_val,
    output logic [31:0] imemresp_data,
    input  logic        dmemreq_val,
    input  logic        dmemreq_type,
    input  logic [31:0] dmemreq_addr,
    input  logic [31:0] dmemreq_wdata,
    output logic        dmemresp_val,
    output logic [31:0] dmemresp_rdata,
    input  logic        ld_val,
    input  logic [31:0] ld_addr,
    input  logic [31:0] ld_data,
    output logic        err
);

    localparam int unsigned IdxW = $clog2(NUM_WORDS);

    logic [31:0]     mem_q [NUM_WORDS];
    logic            i_legal, d_legal, ld_legal;
    logic [IdxW-1:0] i_idx, d_idx, ld_idx;
    logic            st_we, ld_we;
    logic            err_d, err_q;
    mem_resp_t       iresp_in, iresp_out, dresp_in, dresp_out;

    always_comb begin
        i_legal  = addr_legal(imemreq_addr, NUM_WORDS);
        d_legal  = addr_legal(dmemreq_addr, NUM_WORDS);
        ld_legal = addr_legal(ld_addr, NUM_WORDS);
        i_idx    = imemreq_addr[2 +: IdxW];
        d_idx    = dmemreq_addr[2 +: IdxW];
        ld_idx   = ld_addr[2 +: IdxW];

        ld_we = ld_val && ld_legal;
        // A preload to the same word wins; the store is dropped but still answered.
        st_we = dmemreq_val && (dmemreq_type == MEMREQ_WRITE) && d_legal
                && !(ld_we && (ld_idx == d_idx));

        // Array reads see contents before this edge's writes.
        iresp_in.val  = imemreq_val;
        iresp_in.data = (imemreq_val && i_legal) ? mem_q[i_idx] : 32'h0;
        dresp_in.val  = dmemreq_val;
        dresp_in.data = (dmemreq_val && (dmemreq_type == MEMREQ_READ) && d_legal)
                        ? mem_q[d_idx] : 32'h0;

        err_d = err_q
                || (imemreq_val && !i_legal)
                || (dmemreq_val && !d_legal)
                || (ld_val && !ld_legal);
    end

    always_ff @(posedge clk) begin
        if (st_we) begin
            mem_q[d_idx] <= dmemreq_wdata;
        end
        if (ld_we) begin
            mem_q[ld_idx] <= ld_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    proc_mem_resp_pipe #(
        .LATENCY(LATENCY)
    ) u_ipipe (
        .clk    (clk),
        .rst    (rst),
        .resp_i (iresp_in),
        .resp_o (iresp_out)
    );

    proc_mem_resp_pipe #(
        .LATENCY(LATENCY)
    ) u_dpipe (
        .clk    (clk),
        .rst    (rst),
        .resp_i (dresp_in),
        .resp_o (dresp_out)
    );

    assign imemresp_val   = iresp_out.val;
    assign imemresp_data  = iresp_out.data;
    assign dmemresp_val   = dresp_out.val;
    assign dmemresp_rdata = dresp_out.data;
    assign err            = err_q;

endmodule

// File: tb/tb_proc_mem.sv
// Self-checking bench: three instances (latency 0, 2, 3) share one stimulus stream
// and are compared against a per-cycle history of reference responses.
module tb_proc_mem;

    localparam int unsigned NW = 256;

    typedef struct {
        logic        iv;
        logic [31:0] id;
        logic        dv;
        logic [31:0] dd;
    } rsp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        ival, dval, dtype, ldv;
    logic [31:0] iaddr, daddr, wdata, ldaddr, lddata;

    logic        iv_o [3];
    logic [31:0] id_o [3];
    logic        dv_o [3];
    logic [31:0] dd_o [3];
    logic        err_o [3];

    logic        obs_iv [3];
    logic [31:0] obs_id [3];
    logic        obs_dv [3];
    logic [31:0] obs_dd [3];
    logic        obs_err;

    logic [31:0] mdl [NW];
    logic        mdl_err;
    rsp_t        hist [2048];
    int          cyc, valid_from;
    int          tests, fails;
    logic [31:0] saved;

    always #5 clk = ~clk;

    proc_mem #(.NUM_WORDS(NW), .LATENCY(0)) u_l0 (
        .clk(clk), .rst(rst),
        .imemreq_val(ival), .imemreq_addr(iaddr),
        .imemresp_val(iv_o[0]), .imemresp_data(id_o[0]),
        .dmemreq_val(dval), .dmemreq_type(dtype), .dmemreq_addr(daddr), .dmemreq_wdata(wdata),
        .dmemresp_val(dv_o[0]), .dmemresp_rdata(dd_o[0]),
        .ld_val(ldv), .ld_addr(ldaddr), .ld_data(lddata), .err(err_o[0])
    );

    proc_mem #(.NUM_WORDS(NW), .LATENCY(2)) u_l2 (
        .clk(clk), .rst(rst),
        .imemreq_val(ival), .imemreq_addr(iaddr),
        .imemresp_val(iv_o[1]), .imemresp_data(id_o[1]),
        .dmemreq_val(dval), .dmemreq_type(dtype), .dmemreq_addr(daddr), .dmemreq_wdata(wdata),
        .dmemresp_val(dv_o[1]), .dmemresp_rdata(dd_o[1]),
        .ld_val(ldv), .ld_addr(ldaddr), .ld_data(lddata), .err(err_o[1])
    );

    proc_mem #(.NUM_WORDS(NW), .LATENCY(3)) u_l3 (
        .clk(clk), .rst(rst),
        .imemreq_val(ival), .imemreq_addr(iaddr),
        .imemresp_val(iv_o[2]), .imemresp_data(id_o[2]),
        .dmemreq_val(dval), .dmemreq_type(dtype), .dmemreq_addr(daddr), .dmemreq_wdata(wdata),
        .dmemresp_val(dv_o[2]), .dmemresp_rdata(dd_o[2]),
        .ld_val(ldv), .ld_addr(ldaddr), .ld_data(lddata), .err(err_o[2])
    );

    function automatic logic legal(input logic [31:0] a);
        return (a % 4 == 0) && (a < 4 * NW);
    endfunction

    function automatic logic [31:0] rd(input logic [31:0] a);
        return legal(a) ? mdl[a / 4] : 32'h0;
    endfunction

    function automatic int lat_of(input int k);
        return (k == 0) ? 0 : k + 1;
    endfunction

    function automatic logic [31:0] rand_addr();
        int r;
        r = int'($urandom_range(0, 15));
        if (r == 0) return $urandom;
        if (r == 1) return 32'(4 * $urandom_range(0, 15) + 2);
        return 32'(4 * $urandom_range(0, 15));
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        ival = 0; iaddr = 0; dval = 0; dtype = 0; daddr = 0; wdata = 0;
        ldv = 0; ldaddr = 0; lddata = 0;
    endtask

    // One clock: record reference response, check all instances, apply writes, advance.
    task automatic cycle();
        rsp_t cur, exp;
        int   n;
        #1;
        cur.iv = ival;
        cur.id = ival ? rd(iaddr) : 32'h0;
        cur.dv = dval;
        cur.dd = (dval && !dtype) ? rd(daddr) : 32'h0;
        hist[cyc] = cur;
        for (int k = 0; k < 3; k++) begin
            n = lat_of(k);
            if (cyc - n >= valid_from) exp = hist[cyc - n];
            else exp = '{iv: 1'b0, id: 32'h0, dv: 1'b0, dd: 32'h0};
            chk($sformatf("L%0d c%0d ival", n, cyc), 32'(iv_o[k]), 32'(exp.iv));
            chk($sformatf("L%0d c%0d idata", n, cyc), id_o[k], exp.id);
            chk($sformatf("L%0d c%0d dval", n, cyc), 32'(dv_o[k]), 32'(exp.dv));
            chk($sformatf("L%0d c%0d drdata", n, cyc), dd_o[k], exp.dd);
            chk($sformatf("L%0d c%0d err", n, cyc), 32'(err_o[k]), 32'(mdl_err));
            obs_iv[k] = iv_o[k];
            obs_id[k] = id_o[k];
            obs_dv[k] = dv_o[k];
            obs_dd[k] = dd_o[k];
        end
        obs_err = err_o[0];
        if (dval && dtype && legal(daddr)) mdl[daddr / 4] = wdata;
        if (ldv && legal(ldaddr)) mdl[ldaddr / 4] = lddata;
        if ((ival && !legal(iaddr)) || (dval && !legal(daddr)) || (ldv && !legal(ldaddr)))
            mdl_err = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic do_reset();
        clr();
        rst = 1'b1;
        #1;
        for (int k = 1; k < 3; k++) begin
            chk($sformatf("rst flush ival k%0d", k), 32'(iv_o[k]), 32'h0);
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        cyc++;
        valid_from = cyc;
        mdl_err = 1'b0;
    endtask

    initial begin
        tests = 0; fails = 0; cyc = 0; valid_from = 0; mdl_err = 1'b0;
        clr();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("reset ival k%0d", k), 32'(iv_o[k]), 32'h0);
            chk($sformatf("reset dval k%0d", k), 32'(dv_o[k]), 32'h0);
            chk($sformatf("reset idata k%0d", k), id_o[k], 32'h0);
            chk($sformatf("reset drdata k%0d", k), dd_o[k], 32'h0);
            chk($sformatf("reset err k%0d", k), 32'(err_o[k]), 32'h0);
        end
        rst = 1'b0;

        // Fill the whole array so every later read has a defined reference value.
        for (int i = 0; i < int'(NW); i++) begin
            ldv = 1; ldaddr = 32'(i * 4); lddata = $urandom;
            cycle();
        end
        clr();

        // Preload and fetch
        ldv = 1; ldaddr = 32'h200; lddata = 32'h0000_0013; cycle();
        ldaddr = 32'h204; lddata = 32'h00A0_0093; cycle();
        clr();
        ival = 1; iaddr = 32'h200; cycle();
        chk("fetch 0x200 val", 32'(obs_iv[0]), 32'h1);
        chk("fetch 0x200 data", obs_id[0], 32'h0000_0013);
        iaddr = 32'h204; cycle();
        chk("fetch 0x204 data", obs_id[0], 32'h00A0_0093);
        clr();

        // Store/load round trip observed on the latency-2 instance
        dval = 1; dtype = 1; daddr = 32'h100; wdata = 32'hDEAD_BEEF; cycle();
        dtype = 0; cycle();
        clr(); cycle();
        chk("rt t+2 val", 32'(obs_dv[1]), 32'h1);
        chk("rt t+2 data", obs_dd[1], 32'h0);
        cycle();
        chk("rt t+3 val", 32'(obs_dv[1]), 32'h1);
        chk("rt t+3 data", obs_dd[1], 32'hDEAD_BEEF);
        cycle();
        chk("rt t+4 val", 32'(obs_dv[1]), 32'h0);

        // Same-cycle read and write of one word
        ldv = 1; ldaddr = 32'h40; lddata = 32'h11; cycle();
        clr();
        ival = 1; iaddr = 32'h40; dval = 1; dtype = 1; daddr = 32'h40; wdata = 32'h22; cycle();
        chk("rw old data", obs_id[0], 32'h11);
        clr();
        ival = 1; iaddr = 32'h40; cycle();
        chk("rw new data", obs_id[0], 32'h22);
        clr();

        // Preload/store collision
        ldv = 1; ldaddr = 32'h80; lddata = 32'hAAAA_0000;
        dval = 1; dtype = 1; daddr = 32'h80; wdata = 32'h5555; cycle();
        chk("collision store resp", 32'(obs_dv[0]), 32'h1);
        clr();
        dval = 1; daddr = 32'h80; cycle();
        chk("collision read", obs_dd[0], 32'hAAAA_0000);
        clr();

        // Illegal accesses
        saved = mdl[0];
        dval = 1; daddr = 32'h102; cycle();
        chk("misaligned load val", 32'(obs_dv[0]), 32'h1);
        chk("misaligned load data", obs_dd[0], 32'h0);
        chk("err before", 32'(obs_err), 32'h0);
        dtype = 1; daddr = 32'h400; wdata = 32'hFFFF_FFFF; cycle();
        chk("err after illegal load", 32'(obs_err), 32'h1);
        clr(); cycle();
        chk("err sticky", 32'(obs_err), 32'h1);
        dval = 1; daddr = 32'h0; cycle();
        chk("wrap word unchanged", obs_dd[0], saved);
        daddr = 32'h100; cycle();
        chk("0x100 unchanged", obs_dd[0], 32'hDEAD_BEEF);
        clr();

        // Reset with fetches in flight on the latency-3 instance
        ival = 1; iaddr = 32'h200; cycle(); cycle(); cycle();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk($sformatf("post-rst no resp %0d", i), 32'(obs_iv[2]), 32'h0);
        end
        chk("post-rst err", 32'(obs_err), 32'h0);
        ival = 1; iaddr = 32'h200; cycle();
        chk("post-rst fetch L0", obs_id[0], 32'h0000_0013);
        clr(); cycle(); cycle(); cycle();
        chk("post-rst fetch L3 val", 32'(obs_iv[2]), 32'h1);
        chk("post-rst fetch L3 data", obs_id[2], 32'h0000_0013);

        // Randomized traffic concentrated on a few words to force collisions
        for (int i = 0; i < 400; i++) begin
            ival = 1'($urandom_range(0, 1)); iaddr = rand_addr();
            dval = 1'($urandom_range(0, 1)); dtype = 1'($urandom_range(0, 1));
            daddr = rand_addr(); wdata = $urandom;
            ldv = ($urandom_range(0, 3) == 0); ldaddr = rand_addr(); lddata = $urandom;
            cycle();
        end
        clr();
        repeat (4) cycle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
